// File: rtl/wifi_rx_depuncture34.sv
// Rate-3/4 receive depuncturer: expands A1 B1 A2 B3 groups into A1 B1 A2 B2 A3 B3,
// marking the deleted B2/A3 positions as erasures for the Viterbi decoder.
module wifi_rx_depuncture34 #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             valid_in,
  input  logic             data_in,
  output logic             in_ready,
  output logic             valid_out,
  output logic             data_out,
  output logic             erase_out,
  input  logic             out_ready,
  output logic             finished
);

  localparam int unsigned PH_W = 3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [LEN_W-1:0] rem_cnt_q, rem_cnt_d;
  logic             valid_out_q, valid_out_d;
  logic             data_out_q, data_out_d;
  logic             erase_out_q, erase_out_d;
  logic             finished_q, finished_d;
  logic             wait_low_q, wait_low_d;

  logic adv, ers_phase, fire_in, fire_ers, last_in;

  assign adv       = !valid_out_q || out_ready;
  assign ers_phase = (phase_q == PH_W'(3)) || (phase_q == PH_W'(4));
  assign in_ready  = (state_q == RUN) && !ers_phase && adv;
  // A dropped enable aborts, so it also blocks any load on that edge.
  assign fire_in   = in_ready && valid_in && enable;
  assign fire_ers  = (state_q == RUN) && ers_phase && adv && enable;
  assign last_in   = (rem_cnt_q == LEN_W'(1));

  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;
  assign erase_out = erase_out_q;
  assign finished  = finished_q;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      rem_cnt_q   <= '0;
      valid_out_q <= 1'b0;
      data_out_q  <= 1'b0;
      erase_out_q <= 1'b0;
      finished_q  <= 1'b0;
      wait_low_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      rem_cnt_q   <= rem_cnt_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      erase_out_q <= erase_out_d;
      finished_q  <= finished_d;
      wait_low_q  <= wait_low_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable && !wait_low_q) begin
          state_d = (frame_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (fire_in && last_in) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!enable || adv) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_comb begin
    phase_d     = phase_q;
    rem_cnt_d   = rem_cnt_q;
    valid_out_d = valid_out_q && !out_ready;
    data_out_d  = data_out_q;
    erase_out_d = erase_out_q;
    finished_d  = 1'b0;
    wait_low_d  = wait_low_q;
    case (state_q)
      IDLE: begin
        if (!enable) begin
          wait_low_d = 1'b0;
        end else if (!wait_low_q) begin
          rem_cnt_d = frame_len;
          phase_d   = '0;
        end
      end
      RUN: begin
        if (!enable) begin
          valid_out_d = 1'b0;
        end else if (fire_in || fire_ers) begin
          valid_out_d = 1'b1;
          data_out_d  = fire_in ? data_in : 1'b0;
          erase_out_d = fire_ers;
          phase_d     = (phase_q == PH_W'(5)) ? '0 : phase_q + PH_W'(1);
          if (fire_in) begin
            rem_cnt_d = rem_cnt_q - LEN_W'(1);
          end
        end
      end
      DONE: begin
        if (!enable) begin
          valid_out_d = 1'b0;
        end else if (adv) begin
          finished_d = 1'b1;
          wait_low_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wifi_rx_depuncture34.sv
// Self-checking bench for wifi_rx_depuncture34: table of frames against a queue scoreboard,
// plus hand sequences for zero length, abort and mid-frame reset.
module tb_wifi_rx_depuncture34;

  localparam int unsigned LEN_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [LEN_W-1:0] frame_len;
  logic             valid_in;
  logic             data_in;
  logic             in_ready;
  logic             valid_out;
  logic             data_out;
  logic             erase_out;
  logic             out_ready;
  logic             finished;

  wifi_rx_depuncture34 #(.LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_len(frame_len),
    .valid_in(valid_in), .data_in(data_in), .in_ready(in_ready),
    .valid_out(valid_out), .data_out(data_out), .erase_out(erase_out),
    .out_ready(out_ready), .finished(finished)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    logic [63:0] bits;
    int          bp;
    int          npos;
  } vec_t;

  vec_t       tbl[8];
  logic [1:0] q[$];
  int checks = 0;
  int errors = 0;
  int npos = 0;
  int fin_cnt = 0;
  int bp_mode = 0;
  int hold = 0;
  bit held = 1'b0;
  bit prev_stall = 1'b0;
  bit prev_fin = 1'b0;
  logic pd, pe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Output ready generator: always, random, or a single 5-cycle stall on the first erasure
  always @(posedge clk) begin
    #1;
    case (bp_mode)
      1: out_ready = 1'($urandom_range(0, 1));
      2: begin
        if (hold > 0) begin
          out_ready = 1'b0;
          hold--;
        end else if (!held && valid_out && erase_out) begin
          out_ready = 1'b0;
          hold = 4;
          held = 1'b1;
        end else begin
          out_ready = 1'b1;
        end
      end
      default: out_ready = 1'b1;
    endcase
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
      prev_fin = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!(valid_out && data_out === pd && erase_out === pe)) begin
          errors++;
          $display("FAIL hold actual=%b%b%b required=1%b%b", valid_out, data_out, erase_out, pd, pe);
        end
      end
      if (valid_out && out_ready) begin
        npos++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL extra_pos actual=%b%b required=none", data_out, erase_out);
        end else begin
          logic [1:0] exp;
          exp = q.pop_front();
          if ({data_out, erase_out} !== exp) begin
            errors++;
            $display("FAIL pos%0d actual=%b%b required=%b", npos, data_out, erase_out, exp);
          end
        end
      end
      if (finished) begin
        fin_cnt++;
        checks++;
        if (q.size() != 0 || prev_fin) begin
          errors++;
          $display("FAIL finished_early pending=%0d prev=%0d required=0,0", q.size(), prev_fin);
        end
      end
      prev_stall = valid_out && !out_ready;
      pd = data_out;
      pe = erase_out;
      prev_fin = finished;
    end
  end

  // Reference depuncture: erasure pair follows every A2 that is not the last input
  task automatic push_expected(input int len, input logic [63:0] bits);
    for (int i = 0; i < len; i++) begin
      q.push_back({bits[i], 1'b0});
      if (i % 4 == 2 && i < len - 1) begin
        q.push_back(2'b01);
        q.push_back(2'b01);
      end
    end
  endtask

  // Feed n bits starting from posedge+1; returns at posedge+1 after the last accept edge
  task automatic feed(input logic [63:0] bits, input int n, input bit rnd, output int span);
    int idx = 0;
    int cyc = 0;
    int c0 = -1;
    int c1 = -1;
    while (idx < n && cyc < 3000) begin
      valid_in = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      data_in = bits[idx];
      @(negedge clk);
      if (valid_in && in_ready) begin
        if (c0 < 0) c0 = cyc;
        c1 = cyc;
        idx++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    valid_in = 1'b0;
    if (idx < n) check("feed_timeout", 32'(idx), 32'(n));
    span = c1 - c0;
  endtask

  task automatic run_frame(input string name, input int len, input logic [63:0] bits,
                           input int bp, input int exp_npos);
    int span;
    int fin0;
    int npos0;
    int cyc = 0;
    bit idle_ok = 1'b1;
    push_expected(len, bits);
    bp_mode = bp;
    held = 1'b0;
    fin0 = fin_cnt;
    npos0 = npos;
    @(posedge clk);
    #1;
    frame_len = LEN_W'(len);
    enable = 1'b1;
    feed(bits, len, bp != 0, span);
    while (fin_cnt == fin0 && cyc < 3000) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check({name, "_finished"}, 32'(fin_cnt - fin0), 32'd1);
    check({name, "_npos"}, 32'(npos - npos0), 32'(exp_npos));
    check({name, "_pending"}, 32'(q.size()), 32'd0);
    if (bp == 0 && len > 0) check({name, "_span"}, 32'(span), 32'(exp_npos - 1));
    repeat (3) begin
      @(negedge clk);
      if (in_ready || valid_out) idle_ok = 1'b0;
    end
    check({name, "_stay_idle"}, 32'(idle_ok), 32'd1);
    @(posedge clk);
    #1;
    enable = 1'b0;
    bp_mode = 0;
    q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int span;
    int fin0;
    tbl[0] = '{len: 4,  bits: 64'hD, bp: 0, npos: 6};
    tbl[1] = '{len: 48, bits: {$urandom, $urandom}, bp: 0, npos: 72};
    tbl[2] = '{len: 6,  bits: 64'h2D, bp: 0, npos: 8};
    tbl[3] = '{len: 8,  bits: 64'hA7, bp: 2, npos: 12};
    tbl[4] = '{len: 30, bits: {$urandom, $urandom}, bp: 1, npos: 44};
    tbl[5] = '{len: 3,  bits: 64'h5, bp: 0, npos: 3};
    tbl[6] = '{len: 1,  bits: 64'h1, bp: 1, npos: 1};
    tbl[7] = '{len: 0,  bits: 64'h0, bp: 0, npos: 0};

    reset = 1'b0;
    enable = 1'b0;
    frame_len = '0;
    valid_in = 1'b0;
    data_in = 1'b0;
    out_ready = 1'b1;
    #12;
    check("reset_outputs", {27'd0, valid_out, data_out, erase_out, finished, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_frame($sformatf("vec%0d", i), tbl[i].len, tbl[i].bits, tbl[i].bp, tbl[i].npos);
    end

    // frame_len=0: finished appears after the second edge following enable
    @(posedge clk);
    #1;
    frame_len = '0;
    enable = 1'b1;
    fin0 = fin_cnt;
    @(negedge clk);
    @(negedge clk);
    check("len0_fin_early", {30'd0, finished, valid_out}, 32'd0);
    @(negedge clk);
    check("len0_fin_time", {30'd0, finished, valid_out}, 32'd2);
    @(posedge clk);
    #1;
    enable = 1'b0;
    @(posedge clk);
    #1;

    // Abort at phase 3: A2 just loaded, erasures must not follow
    q.push_back(2'b10);
    q.push_back(2'b10);
    q.push_back(2'b00);
    fin0 = fin_cnt;
    frame_len = LEN_W'(8);
    enable = 1'b1;
    feed(64'h3, 3, 1'b0, span);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_valid", {31'd0, valid_out}, 32'd0);
    check("abort_pending", 32'(q.size()), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_no_fin", 32'(fin_cnt - fin0), 32'd0);
    q.delete();

    // Reset mid-frame after five inputs
    @(posedge clk);
    #1;
    push_expected(5, 64'h15);
    frame_len = LEN_W'(12);
    enable = 1'b1;
    feed(64'h15, 5, 1'b0, span);
    reset = 1'b0;
    enable = 1'b0;
    #2;
    check("rst_mid_outputs", {27'd0, valid_out, data_out, erase_out, finished, in_ready}, 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;

    run_frame("post_rst4", 4, 64'hD, 0, 6);
    run_frame("post_rst6", 6, 64'h1A, 1, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
